stencil_2d_stream: RTL and testbench

STENCIL_2D_STREAM -- requirements
Module: stencil_2d_stream

---
 rtl/stencil_2d_stream.sv | 177 +++++++++++++++++
 tb/tb_stencil_2d_stream.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stencil_2d_stream.sv
// Streaming KxK signed 2D convolution over a raster-order image, run as a
// start/done call with line buffers, a sliding window and a 1-cycle output register.
module stencil_2d_stream #(
  parameter int DATA_W   = 16,
  parameter int K        = 3,
  parameter int MAX_COLS = 64
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   start,
  output logic                                   busy,
  output logic                                   done,
  input  logic                                   stall,
  output logic [31:0]                            returndata,
  input  logic [15:0]                            cfg_rows,
  input  logic [15:0]                            cfg_cols,
  input  logic                                   coef_wr,
  input  logic [$clog2(K*K)-1:0]                 coef_addr,
  input  logic signed [DATA_W-1:0]               coef_data,
  input  logic                                   in_valid,
  input  logic signed [DATA_W-1:0]               in_data,
  output logic                                   in_ready,
  output logic                                   out_valid,
  output logic signed [2*DATA_W+$clog2(K*K)-1:0] out_data,
  input  logic                                   out_stall
);

  localparam int ACC_W = 2*DATA_W + $clog2(K*K);
  localparam int NC    = K*K;
  localparam int LA_W  = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [15:0] K_16    = 16'(K);
  localparam logic [15:0] KM1_16  = 16'(K-1);
  localparam logic [15:0] MAXC_16 = 16'(MAX_COLS);

  logic [1:0]  state_q, state_d;
  logic [15:0] rows_q, cols_q, row_q, col_q;
  logic [31:0] cnt_q;
  logic        err_q;
  logic        out_valid_q;
  logic signed [ACC_W-1:0]  out_data_q;
  logic signed [DATA_W-1:0] coef_q [NC];
  logic signed [DATA_W-1:0] win_q  [K][K];
  logic signed [DATA_W-1:0] win_d  [K][K];
  logic signed [DATA_W-1:0] lb_rd  [K-1];
  logic signed [2*DATA_W-1:0] prod [NC];
  logic signed [ACC_W-1:0]  acc;

  logic start_acc, bad_cfg, accept, last_px, col_wrap, emit, consume;

  assign start_acc = (state_q == S_IDLE) && start;
  assign bad_cfg   = (cfg_rows < K_16) || (cfg_cols < K_16) || (cfg_cols > MAXC_16);
  assign in_ready  = (state_q == S_RUN) && !(out_valid_q && out_stall);
  assign accept    = in_valid && in_ready;
  assign col_wrap  = (col_q == cols_q - 16'd1);
  assign last_px   = col_wrap && (row_q == rows_q - 16'd1);
  assign emit      = (row_q >= KM1_16) && (col_q >= KM1_16);
  assign consume   = out_valid_q && !out_stall;

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign returndata = done ? (err_q ? 32'hFFFF_FFFF : cnt_q) : 32'd0;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;

  // Line buffer gi holds row r-1-gi at each column; rows cascade on every accepted pixel.
  genvar gi;
  generate
    for (gi = 0; gi < K-1; gi++) begin : g_lb
      logic signed [DATA_W-1:0] mem [MAX_COLS];
      logic signed [DATA_W-1:0] wr_val;
      if (gi == 0) begin : g_first
        assign wr_val = in_data;
      end else begin : g_rest
        assign wr_val = lb_rd[gi-1];
      end
      assign lb_rd[gi] = mem[col_q[LA_W-1:0]];
      always_ff @(posedge clock) begin
        if (accept) begin
          mem[col_q[LA_W-1:0]] <= wr_val;
        end
      end
    end
  endgenerate

  // Window row 0 is the oldest image row, column K-1 the newest pixel.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K-1; j++) begin
        win_d[i][j] = win_q[i][j+1];
      end
    end
    for (int i = 0; i < K-1; i++) begin
      win_d[i][K-1] = lb_rd[K-2-i];
    end
    win_d[K-1][K-1] = in_data;
  end

  generate
    for (gi = 0; gi < NC; gi++) begin : g_prod
      assign prod[gi] = win_d[gi / K][gi % K] * coef_q[gi];
    end
  endgenerate

  always_comb begin
    acc = '0;
    for (int n = 0; n < NC; n++) begin
      acc = acc + ACC_W'(prod[n]);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = bad_cfg ? S_DONE : S_RUN;
      S_RUN:   if (accept && last_px) state_d = S_DRAIN;
      S_DRAIN: if (!out_valid_q) state_d = S_DONE;
      S_DONE:  if (!stall) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rows_q      <= '0;
      cols_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int n = 0; n < NC; n++) coef_q[n] <= '0;
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K; j++) win_q[i][j] <= '0;
      end
    end else begin
      state_q <= state_d;
      if ((state_q == S_IDLE) && coef_wr && (int'(coef_addr) < NC)) begin
        coef_q[coef_addr] <= coef_data;
      end
      if (consume) begin
        cnt_q <= cnt_q + 32'd1;
      end
      if (start_acc) begin
        rows_q <= cfg_rows;
        cols_q <= cfg_cols;
        row_q  <= '0;
        col_q  <= '0;
        cnt_q  <= '0;
        err_q  <= bad_cfg;
      end
      if (accept) begin
        win_q <= win_d;
        if (col_wrap) begin
          col_q <= '0;
          row_q <= row_q + 16'd1;
        end else begin
          col_q <= col_q + 16'd1;
        end
      end
      if (accept && emit) begin
        out_valid_q <= 1'b1;
        out_data_q  <= acc;
      end else if (consume) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stencil_2d_stream.sv
// Directed bench for stencil_2d_stream: a reference convolution fills a scoreboard
// queue as each call starts; consumed results are popped and compared.
module tb_stencil_2d_stream;

  localparam int KK   = 3;
  localparam int MAXC = 64;

  logic clock = 1'b0;
  logic reset, start, stall, coef_wr, in_valid, out_stall;
  logic busy, done, in_ready, out_valid;
  logic [31:0] returndata;
  logic [15:0] cfg_rows, cfg_cols;
  logic [3:0]  coef_addr;
  logic signed [15:0] coef_data, in_data;
  logic signed [35:0] out_data;

  stencil_2d_stream #(.DATA_W(16), .K(KK), .MAX_COLS(MAXC)) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .stall(stall), .returndata(returndata), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_stall(out_stall)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  logic signed [35:0] exp_q [$];
  int img   [256];
  int coefm [9];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && out_valid && !out_stall) begin
      check("output_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        logic signed [35:0] e;
        e = exp_q.pop_front();
        $display("out #%0d data=%0d expected=%0d", n_out, out_data, e);
        check("out_data", 64'(out_data), 64'(e));
      end
      n_out++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_coefs();
    for (int n = 0; n < 9; n++) begin
      coef_wr   = 1'b1;
      coef_addr = 4'(n);
      coef_data = 16'(coefm[n]);
      tick();
    end
    coef_wr = 1'b0;
  endtask

  task automatic push_expected(input int rows, input int cols);
    for (int r = KK-1; r < rows; r++) begin
      for (int c = KK-1; c < cols; c++) begin
        longint s;
        s = 0;
        for (int i = 0; i < KK; i++) begin
          for (int j = 0; j < KK; j++) begin
            s += longint'(img[(r-KK+1+i)*cols + (c-KK+1+j)]) * longint'(coefm[i*KK+j]);
          end
        end
        exp_q.push_back(s[35:0]);
      end
    end
  endtask

  task automatic start_call(input int rows, input int cols);
    cfg_rows = 16'(rows);
    cfg_cols = 16'(cols);
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic send_pixel(input int val);
    bit got;
    got      = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'(val);
    for (int k = 0; k < 500 && !got; k++) begin
      @(negedge clock);
      if (in_ready) begin
        got = 1'b1;
        tick();
      end
    end
    in_valid = 1'b0;
    assert (got) else begin
      n_checks++;
      n_fail++;
      $error("FAIL pixel_accept_timeout observed=no_accept expected=accept");
    end
  endtask

  task automatic send_image(input int rows, input int cols);
    for (int p = 0; p < rows*cols; p++) send_pixel(img[p]);
  endtask

  task automatic wait_done(input int exp_ret);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 500 && !got; k++) begin
      @(negedge clock);
      if (done) got = 1'b1;
    end
    check("done_reached", 64'(got), 64'd1);
    check("returndata", 64'(returndata), 64'(exp_ret));
  endtask

  task automatic finish_call(input int rows, input int cols);
    wait_done((rows-KK+1)*(cols-KK+1));
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("output_count", 64'(n_out), 64'((rows-KK+1)*(cols-KK+1)));
    tick();
    check("idle_after_done", 64'(busy), 64'd0);
  endtask

  task automatic run_call(input int rows, input int cols);
    n_out = 0;
    push_expected(rows, cols);
    start_call(rows, cols);
    send_image(rows, cols);
    finish_call(rows, cols);
  endtask

  task automatic stall_second_output();
    bit fired;
    fired = 1'b0;
    for (int k = 0; k < 400 && !fired; k++) begin
      tick();
      if (out_valid && n_out == 1) begin
        fired     = 1'b1;
        out_stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
          @(negedge clock);
          check("stall_in_ready", 64'(in_ready), 64'd0);
          check("stall_out_valid", 64'(out_valid), 64'd1);
          check("stall_out_held", 64'(out_data), 64'(exp_q[0]));
          tick();
        end
        out_stall = 1'b0;
      end
    end
    check("stall_injected", 64'(fired), 64'd1);
  endtask

  task automatic poke_during_run();
    repeat (6) tick();
    coef_wr   = 1'b1;
    coef_addr = 4'd4;
    coef_data = 16'sd7;
    start     = 1'b1;
    cfg_rows  = 16'd3;
    cfg_cols  = 16'd3;
    tick();
    coef_wr = 1'b0;
    start   = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0; coef_wr = 1'b0; in_valid = 1'b0;
    out_stall = 1'b0; cfg_rows = '0; cfg_cols = '0; coef_addr = '0;
    coef_data = '0; in_data = '0;
    repeat (3) tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_returndata", 64'(returndata), 64'd0);
    reset = 1'b0;
    tick();

    // Identity filter on a 4x4 ramp: 5, 6, 9, 10
    for (int n = 0; n < 9; n++) coefm[n] = (n == 4) ? 1 : 0;
    load_coefs();
    for (int p = 0; p < 16; p++) img[p] = p;
    run_call(4, 4);

    // All-ones filter over an all-ones 5x5 image, then again with a stall
    for (int n = 0; n < 9; n++) coefm[n] = 1;
    load_coefs();
    for (int p = 0; p < 25; p++) img[p] = 1;
    run_call(5, 5);
    n_out = 0;
    push_expected(5, 5);
    start_call(5, 5);
    fork
      send_image(5, 5);
      stall_second_output();
    join
    finish_call(5, 5);

    // Illegal geometry: immediate DONE with error code; DONE holds under stall
    stall    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'sd5;
    start_call(5, 2);
    @(negedge clock);
    check("err_done", 64'(done), 64'd1);
    check("err_returndata", 64'(returndata), 64'hFFFF_FFFF);
    check("err_in_ready", 64'(in_ready), 64'd0);
    repeat (2) begin
      tick();
      check("err_done_held", 64'(done), 64'd1);
    end
    stall = 1'b0;
    tick();
    check("err_idle", 64'(busy), 64'd0);
    start_call(2, 5);
    @(negedge clock);
    check("err_rows_returndata", 64'(returndata), 64'hFFFF_FFFF);
    tick();
    start_call(3, MAXC+1);
    @(negedge clock);
    check("err_cols_returndata", 64'(returndata), 64'hFFFF_FFFF);
    check("err_no_output", 64'(out_valid), 64'd0);
    tick();
    in_valid = 1'b0;

    // Asymmetric signed coefficients, non-square image and full-width rows
    coefm = '{1, -2, 3, -4, 5, -6, 7, -8, 9};
    load_coefs();
    for (int p = 0; p < 256; p++) img[p] = (p * 7) % 23 - 11;
    run_call(5, 6);
    run_call(3, MAXC);

    // Coefficient write and start while running are both ignored
    n_out = 0;
    push_expected(5, 5);
    start_call(5, 5);
    fork
      send_image(5, 5);
      poke_during_run();
    join
    finish_call(5, 5);
    run_call(5, 5);

    // Extreme operands need the full accumulator width
    for (int n = 0; n < 9; n++) coefm[n] = -32768;
    load_coefs();
    for (int p = 0; p < 9; p++) img[p] = -32768;
    run_call(3, 3);

    // Reset in the middle of a call
    for (int n = 0; n < 9; n++) coefm[n] = 1;
    load_coefs();
    for (int p = 0; p < 25; p++) img[p] = 1;
    start_call(5, 5);
    for (int p = 0; p < 10; p++) send_pixel(1);
    reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd0);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_out_data", 64'(out_data), 64'd0);
    check("abort_returndata", 64'(returndata), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    for (int n = 0; n < 9; n++) coefm[n] = 0;
    for (int p = 0; p < 9; p++) img[p] = p + 3;
    run_call(3, 3);
    for (int n = 0; n < 9; n++) coefm[n] = 1;
    load_coefs();
    for (int p = 0; p < 25; p++) img[p] = 1;
    run_call(5, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
